// File: rtl/mpu_collector_array.sv
// Result collector for a ROWS x COLS FMA cluster: gathers ready cells of the active
// m x n sub-array round-robin and streams them into the matrix register file.
module mpu_collector_array #(
   parameter int FP_WIDTH = 32,
   parameter int ROWS     = 3,
   parameter int COLS     = 3,
   parameter int ADDR_W   = 4,
   parameter int IDX_W    = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_in,
   input  logic [ADDR_W-1:0]             dest_addr_in,
   input  logic [IDX_W-1:0]              m_size_in,
   input  logic [IDX_W-1:0]              n_size_in,
   input  logic [ROWS*COLS*FP_WIDTH-1:0] result_in,
   input  logic [ROWS*COLS-1:0]          ready_in,
   output logic [ROWS*COLS-1:0]          result_ack_out,
   input  logic                          reg_ready_in,
   output logic                          reg_collector_en_out,
   output logic [ADDR_W-1:0]             reg_collector_addr_out,
   output logic [IDX_W-1:0]              reg_collector_i_out,
   output logic [IDX_W-1:0]              reg_collector_j_out,
   output logic [FP_WIDTH-1:0]           reg_collector_element_out,
   output logic                          busy_out,
   output logic                          done_out,
   output logic                          error_out
);

   localparam int NCELL = ROWS * COLS;
   localparam int PTR_W = (NCELL > 1) ? $clog2(NCELL) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [NCELL-1:0]      pending_q, pending_d;
   logic [PTR_W-1:0]      rr_q, rr_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  error_q, error_d;
   logic                  out_en_q, out_en_d;
   logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
   logic [IDX_W-1:0]      out_i_q, out_i_d;
   logic [IDX_W-1:0]      out_j_q, out_j_d;
   logic [FP_WIDTH-1:0]   out_elem_q, out_elem_d;

   logic                  sizes_ok;
   logic [NCELL-1:0]      start_mask;
   logic [NCELL-1:0]      eligible;
   logic                  out_free;
   logic                  accept;
   logic                  grant_found;
   logic [PTR_W-1:0]      grant_idx;
   logic                  capture;
   int                    cand;

   always_comb begin
      sizes_ok = (m_size_in != '0) && (int'(m_size_in) <= ROWS) &&
                 (n_size_in != '0) && (int'(n_size_in) <= COLS);
      start_mask = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if ((r < int'(m_size_in)) && (c < int'(n_size_in))) begin
               start_mask[r*COLS + c] = 1'b1;
            end
         end
      end
   end

   // Round-robin search: first eligible cell at or after the pointer, wrapping.
   always_comb begin
      eligible    = ready_in & pending_q;
      accept      = out_en_q & reg_ready_in;
      out_free    = ~out_en_q | reg_ready_in;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NCELL; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NCELL) begin
            cand = cand - NCELL;
         end
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(cand);
         end
      end
      capture = (state_q == S_COLLECT) && grant_found && out_free;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         rr_q       <= '0;
         addr_q     <= '0;
         error_q    <= 1'b0;
         out_en_q   <= 1'b0;
         out_addr_q <= '0;
         out_i_q    <= '0;
         out_j_q    <= '0;
         out_elem_q <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         rr_q       <= rr_d;
         addr_q     <= addr_d;
         error_q    <= error_d;
         out_en_q   <= out_en_d;
         out_addr_q <= out_addr_d;
         out_i_q    <= out_i_d;
         out_j_q    <= out_j_d;
         out_elem_q <= out_elem_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rr_d      = rr_q;
      addr_d    = addr_q;
      error_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               if (sizes_ok) begin
                  state_d   = S_COLLECT;
                  pending_d = start_mask;
                  addr_d    = dest_addr_in;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            error_d = start_in;
            if (capture) begin
               pending_d[grant_idx] = 1'b0;
               rr_d = (grant_idx == PTR_W'(NCELL - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            if ((pending_q == '0) && out_free) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            error_d = start_in;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A capture reloads the output register in the same cycle an accept empties it.
   always_comb begin
      out_en_d   = out_en_q;
      out_addr_d = out_addr_q;
      out_i_d    = out_i_q;
      out_j_d    = out_j_q;
      out_elem_d = out_elem_q;
      if (capture) begin
         out_en_d   = 1'b1;
         out_addr_d = addr_q;
         out_i_d    = IDX_W'(int'(grant_idx) / COLS);
         out_j_d    = IDX_W'(int'(grant_idx) % COLS);
         out_elem_d = result_in[grant_idx*FP_WIDTH +: FP_WIDTH];
      end else if (accept) begin
         out_en_d = 1'b0;
      end

      result_ack_out            = capture ? (NCELL'(1) << grant_idx) : '0;
      reg_collector_en_out      = out_en_q;
      reg_collector_addr_out    = out_addr_q;
      reg_collector_i_out       = out_i_q;
      reg_collector_j_out       = out_j_q;
      reg_collector_element_out = out_elem_q;
      busy_out                  = (state_q == S_COLLECT) || (state_q == S_DONE);
      done_out                  = (state_q == S_DONE);
      error_out                 = error_q;
   end

endmodule

// File: tb/tb_mpu_collector_array.sv
// Scoreboard bench for mpu_collector_array: stimulus pushes expected acks/writes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mpu_collector_array;

   localparam int FPW = 32;
   localparam int R   = 3;
   localparam int C   = 3;
   localparam int AW  = 4;
   localparam int IW  = 3;
   localparam int N   = R * C;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_in;
   logic [AW-1:0]    dest_addr_in;
   logic [IW-1:0]    m_size_in, n_size_in;
   logic [N*FPW-1:0] result_in;
   logic [N-1:0]     ready_in;
   logic [N-1:0]     result_ack_out;
   logic             reg_ready_in;
   logic             en_o;
   logic [AW-1:0]    addr_o;
   logic [IW-1:0]    i_o, j_o;
   logic [FPW-1:0]   elem_o;
   logic             busy_out, done_out, error_out;

   always #5 clk = ~clk;

   mpu_collector_array #(.FP_WIDTH(FPW), .ROWS(R), .COLS(C), .ADDR_W(AW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .dest_addr_in(dest_addr_in),
      .m_size_in(m_size_in), .n_size_in(n_size_in), .result_in(result_in),
      .ready_in(ready_in), .result_ack_out(result_ack_out), .reg_ready_in(reg_ready_in),
      .reg_collector_en_out(en_o), .reg_collector_addr_out(addr_o),
      .reg_collector_i_out(i_o), .reg_collector_j_out(j_o),
      .reg_collector_element_out(elem_o), .busy_out(busy_out), .done_out(done_out),
      .error_out(error_out)
   );

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic [IW-1:0]  i;
      logic [IW-1:0]  j;
      logic [FPW-1:0] elem;
   } wr_t;

   wr_t  exp_wr[$];
   int   exp_ack[$];
   int   tests = 0, fails = 0;
   int   ack_count = 0, acc_count = 0, cyc = 0, last_acc_cyc = -10;
   logic [7:0] tag = 8'h00;

   always_comb begin
      for (int k = 0; k < N; k++) result_in[k*FPW +: FPW] = {8'hA5, tag, 16'(k)};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_cell(input logic [AW-1:0] a, input int k);
      wr_t w;
      w.addr = a;
      w.i    = IW'(k / C);
      w.j    = IW'(k % C);
      w.elem = {8'hA5, tag, 16'(k)};
      exp_wr.push_back(w);
      exp_ack.push_back(k);
   endtask

   // Monitor: ack order, write data, stall stability, done timing, reset quiet.
   wr_t        cur, prev;
   logic       prev_stall = 1'b0;
   int         mk;
   logic [N-1:0] oh;
   always @(negedge clk) begin
      cyc++;
      cur = {addr_o, i_o, j_o, elem_o};
      if (!rst) begin
         check("rst_quiet", 64'({result_ack_out, en_o}), 64'(0));
         prev_stall = 1'b0;
      end else begin
         if (result_ack_out != '0) begin
            ack_count++;
            check("ack_onehot", 64'($onehot(result_ack_out)), 64'(1));
            if (exp_ack.size() == 0) begin
               check("ack_unexpected", 64'(result_ack_out), 64'(0));
            end else begin
               mk = exp_ack.pop_front();
               oh = '0;
               oh[mk] = 1'b1;
               check("ack_cell", 64'(result_ack_out), 64'(oh));
            end
         end
         if (prev_stall) check("stall_stable", 64'({en_o, cur}), 64'({1'b1, prev}));
         if (en_o && reg_ready_in) begin
            acc_count++;
            last_acc_cyc = cyc;
            if (exp_wr.size() == 0) check("write_unexpected", 64'(cur), 64'(0));
            else check("write", 64'(cur), 64'(exp_wr.pop_front()));
         end
         if (done_out) begin
            check("done_after_accept", 64'(cyc - last_acc_cyc), 64'(1));
            check("done_queue_empty", 64'(exp_wr.size() + exp_ack.size()), 64'(0));
         end
         prev_stall = en_o && !reg_ready_in;
         prev = cur;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_coll(input logic [AW-1:0] a, input int m, input int n);
      start_in = 1'b1;
      dest_addr_in = a;
      m_size_in = IW'(m);
      n_size_in = IW'(n);
      step();
      start_in = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int lat);
      bit found = 0;
      lat = 0;
      for (int c = 1; c <= bound; c++) begin
         @(negedge clk);
         if (done_out) begin
            lat = c;
            found = 1;
            break;
         end
      end
      if (!found) check("done_timeout", 64'(0), 64'(1));
   endtask

   task automatic wait_acks(input int target, input int bound);
      bit found = 0;
      for (int c = 0; c < bound; c++) begin
         step();
         if (ack_count >= target) begin
            found = 1;
            break;
         end
      end
      if (!found) check("ack_timeout", 64'(ack_count), 64'(target));
   endtask

   task automatic wait_accs(input int target, input int bound);
      bit found = 0;
      for (int c = 0; c < bound; c++) begin
         step();
         if (acc_count >= target) begin
            found = 1;
            break;
         end
      end
      if (!found) check("accept_timeout", 64'(acc_count), 64'(target));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_en"}, 64'(en_o), 64'(0));
      check({name, "_ack"}, 64'(result_ack_out), 64'(0));
      check({name, "_busy"}, 64'(busy_out), 64'(0));
      check({name, "_done"}, 64'(done_out), 64'(0));
      check({name, "_error"}, 64'(error_out), 64'(0));
      check({name, "_wdata"}, 64'({addr_o, i_o, j_o, elem_o}), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int lat, base;
   initial begin
      rst = 1'b0; start_in = 1'b0; dest_addr_in = '0; m_size_in = '0; n_size_in = '0;
      ready_in = '0; reg_ready_in = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      step();
      rst = 1'b1;

      // Full 3x3, free-running register file.
      tag = 8'h01; ready_in = '1; reg_ready_in = 1'b1; base = ack_count;
      for (int k = 0; k < N; k++) push_cell(4'd5, k);
      start_coll(4'd5, 3, 3);
      wait_done(40, lat);
      check("t1_latency", 64'(lat), 64'(11));
      @(negedge clk);
      check("t1_busy_after", 64'(busy_out), 64'(0));
      check("t1_acks", 64'(ack_count - base), 64'(9));

      // 2x1 sub-array with every cell ready.
      step();
      tag = 8'h02; base = ack_count;
      push_cell(4'd9, 0);
      push_cell(4'd9, 3);
      start_coll(4'd9, 2, 1);
      wait_done(30, lat);
      check("t2_latency", 64'(lat), 64'(4));
      @(negedge clk);
      check("t2_busy_after", 64'(busy_out), 64'(0));
      check("t2_acks", 64'(ack_count - base), 64'(2));

      // Back-pressure: pointer is at 4 after the previous run.
      step();
      tag = 8'h03; reg_ready_in = 1'b0; base = ack_count;
      for (int k = 0; k < N; k++) push_cell(4'd2, (k + 4) % N);
      start_coll(4'd2, 3, 3);
      repeat (5) @(negedge clk);
      check("t3_stall_acks", 64'(ack_count - base), 64'(1));
      check("t3_stall_en", 64'(en_o), 64'(1));
      check("t3_stall_ij", 64'({i_o, j_o}), 64'({3'd1, 3'd1}));
      step();
      reg_ready_in = 1'b1;
      wait_done(40, lat);
      check("t3_acks", 64'(ack_count - base), 64'(9));

      // Round robin: pointer 4, cells 1,3 then 0,4 ready in a 2x2 run.
      step();
      tag = 8'h04; base = ack_count;
      ready_in = 9'b000001010;
      push_cell(4'd7, 1); push_cell(4'd7, 3); push_cell(4'd7, 4); push_cell(4'd7, 0);
      start_coll(4'd7, 2, 2);
      wait_acks(base + 2, 20);
      ready_in = 9'b000011011;
      wait_done(30, lat);
      check("t4a_acks", 64'(ack_count - base), 64'(4));

      // Pointer now 1: cell 4 must win over cell 0.
      step();
      tag = 8'h05; base = ack_count;
      ready_in = 9'b000010001;
      push_cell(4'd3, 4); push_cell(4'd3, 0);
      for (int k = 1; k < N; k++) if (k != 4) push_cell(4'd3, k);
      start_coll(4'd3, 3, 3);
      wait_acks(base + 2, 20);
      ready_in = '1;
      wait_done(40, lat);
      check("t4b_acks", 64'(ack_count - base), 64'(9));

      // Rejected starts.
      step();
      tag = 8'h06;
      start_coll(4'd1, 0, 3);
      @(negedge clk);
      check("t5_m0_error", 64'(error_out), 64'(1));
      check("t5_m0_busy", 64'(busy_out), 64'(0));
      @(negedge clk);
      check("t5_error_pulse", 64'(error_out), 64'(0));
      step();
      start_coll(4'd1, 4, 3);
      @(negedge clk);
      check("t5_m4_error", 64'(error_out), 64'(1));
      check("t5_m4_busy", 64'(busy_out), 64'(0));
      step();
      for (int k = 0; k < N; k++) push_cell(4'd6, k);
      start_coll(4'd6, 3, 3);
      repeat (3) step();
      start_coll(4'd15, 1, 1);
      @(negedge clk);
      check("t5_busy_error", 64'(error_out), 64'(1));
      check("t5_busy_still", 64'(busy_out), 64'(1));
      wait_done(40, lat);

      // Reset mid-collection after three writes.
      step();
      tag = 8'h07; base = acc_count;
      for (int k = 0; k < N; k++) push_cell(4'd11, k);
      start_coll(4'd11, 3, 3);
      wait_accs(base + 3, 20);
      rst = 1'b0;
      #1;
      check_all_zero("t6_rst");
      exp_wr.delete();
      exp_ack.delete();
      repeat (3) @(negedge clk);
      step();
      rst = 1'b1;
      base = ack_count;
      repeat (3) @(negedge clk);
      check("t6_no_acks", 64'(ack_count - base), 64'(0));
      check("t6_idle", 64'({busy_out, en_o}), 64'(0));
      step();
      tag = 8'h08;
      for (int k = 0; k < N; k++) push_cell(4'd11, k);
      start_coll(4'd11, 3, 3);
      wait_done(40, lat);
      check("t6_restart_acks", 64'(ack_count - base), 64'(9));
      check("t6_restart_latency", 64'(lat), 64'(11));

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
